// File: rtl/vga_text_engine.sv
// Character-cell VGA text renderer: timing generator, text RAM, external font
// fetch, fixed CGA palette, blinking underline cursor and a hardware screen clear.
module vga_text_engine #(
   parameter int H_SYNC       = 112,
   parameter int H_BACK       = 248,
   parameter int H_DISP       = 1280,
   parameter int H_FRONT      = 48,
   parameter int V_SYNC       = 3,
   parameter int V_BACK       = 38,
   parameter int V_DISP       = 1024,
   parameter int V_FRONT      = 1,
   parameter int CHAR_W       = 8,
   parameter int CHAR_H       = 16,
   parameter bit HS_POL       = 1'b1,
   parameter bit VS_POL       = 1'b1,
   parameter int BLINK_FRAMES = 32,
   localparam int COLS        = H_DISP / CHAR_W,
   localparam int ROWS        = V_DISP / CHAR_H,
   localparam int CELLS       = COLS * ROWS,
   localparam int AW          = $clog2(CELLS),
   localparam int FW          = 8 + $clog2(CHAR_H)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [7:0]        i_wr_char,
   input  logic [7:0]        i_wr_attr,
   input  logic              i_clear,
   output logic              o_clear_busy,
   input  logic              i_cursor_en,
   input  logic [AW-1:0]     i_cursor_addr,
   output logic [FW-1:0]     o_font_addr,
   input  logic [CHAR_W-1:0] i_font_data,
   output logic [3:0]        o_vga_r,
   output logic [3:0]        o_vga_g,
   output logic [3:0]        o_vga_b,
   output logic              o_vga_hs,
   output logic              o_vga_vs,
   output logic              o_frame_start
);
   localparam int HT  = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int VT  = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int HDS = H_SYNC + H_BACK;
   localparam int VDS = V_SYNC + V_BACK;
   localparam int HW  = $clog2(HT);
   localparam int VW  = $clog2(VT);
   localparam int XW  = $clog2(CHAR_W);
   localparam int YW  = $clog2(CHAR_H);
   localparam int BW  = $clog2(BLINK_FRAMES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_DONE} state_t;

   function automatic logic [11:0] cga(input logic [3:0] idx);
      case (idx)
         4'd0:    return 12'h000;
         4'd1:    return 12'h00A;
         4'd2:    return 12'h0A0;
         4'd3:    return 12'h0AA;
         4'd4:    return 12'hA00;
         4'd5:    return 12'hA0A;
         4'd6:    return 12'hA50;
         4'd7:    return 12'hAAA;
         4'd8:    return 12'h555;
         4'd9:    return 12'h55F;
         4'd10:   return 12'h5F5;
         4'd11:   return 12'h5FF;
         4'd12:   return 12'hF55;
         4'd13:   return 12'hF5F;
         4'd14:   return 12'hFF5;
         default: return 12'hFFF;
      endcase
   endfunction

   // ---------------- S0: raster counters ----------------
   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic          w_disp, w_hs, w_vs, w_frame_start;
   logic [HW-1:0] w_x, w_col;
   logic [VW-1:0] w_y, w_row;
   logic [XW-1:0] w_xoff;
   logic [YW-1:0] w_yoff;
   logic [AW-1:0] w_addr, w_rd_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (r_hcnt == HW'(HT - 1)) begin
         r_hcnt <= '0;
         r_vcnt <= (r_vcnt == VW'(VT - 1)) ? '0 : r_vcnt + VW'(1);
      end else begin
         r_hcnt <= r_hcnt + HW'(1);
      end
   end

   assign w_disp = (r_hcnt >= HW'(HDS)) && (r_hcnt < HW'(HDS + H_DISP)) &&
                   (r_vcnt >= VW'(VDS)) && (r_vcnt < VW'(VDS + V_DISP));
   assign w_x    = r_hcnt - HW'(HDS);
   assign w_y    = r_vcnt - VW'(VDS);
   assign w_col  = w_x / HW'(CHAR_W);
   assign w_row  = w_y / VW'(CHAR_H);
   assign w_xoff = XW'(w_x % HW'(CHAR_W));
   assign w_yoff = YW'(w_y % VW'(CHAR_H));
   assign w_addr = AW'(32'(w_row) * 32'(COLS) + 32'(w_col));
   // Keep the RAM index in range while blanking.
   assign w_rd_addr = w_disp ? w_addr : '0;

   assign w_hs = (r_hcnt < HW'(H_SYNC)) ? HS_POL : ~HS_POL;
   assign w_vs = (r_vcnt < VW'(V_SYNC)) ? VS_POL : ~VS_POL;
   assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
   assign o_frame_start = i_rst_n && w_frame_start;

   // ---------------- cursor blink ----------------
   logic          r_blink_on;
   logic [BW-1:0] r_blink_cnt;

   // The first pulse after reset only starts frame 0, so the phase flips on
   // pulse BLINK_FRAMES+1 and every BLINK_FRAMES pulses after that.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blink_on  <= 1'b1;
         r_blink_cnt <= '0;
      end else if (w_frame_start) begin
         if (r_blink_cnt == BW'(BLINK_FRAMES)) begin
            r_blink_on  <= ~r_blink_on;
            r_blink_cnt <= BW'(1);
         end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
         end
      end
   end

   // ---------------- clear FSM and write port ----------------
   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_clr_addr;
   logic          w_busy, w_wr_fire, w_ram_we;
   logic [AW-1:0] w_ram_waddr;
   logic [15:0]   w_ram_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= (r_state == ST_CLR) ? r_clr_addr + AW'(1) : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_ram_we    = 1'b0;
      w_ram_waddr = i_wr_addr;
      w_ram_wdata = {i_wr_attr, i_wr_char};
      unique case (r_state)
         ST_IDLE: begin
            w_busy   = 1'b0;
            w_ram_we = w_wr_fire;
            if (i_clear) w_state_nxt = ST_CLR;
         end
         ST_CLR: begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_clr_addr;
            w_ram_wdata = 16'h0720;
            if (r_clr_addr == AW'(CELLS - 1)) w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_clear_busy = w_busy;
   assign o_wr_ready   = !w_busy && !i_clear;
   assign w_wr_fire    = i_wr_valid && o_wr_ready && (32'(i_wr_addr) < CELLS);

   logic [15:0] r_ram [CELLS];

   always_ff @(posedge i_clk) begin
      if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
   end

   // ---------------- S1..S3 pixel pipeline ----------------
   logic [15:0]   r_ram_q;
   logic          r_s1_disp, r_s1_cur, r_s2_disp, r_s2_cur;
   logic [XW-1:0] r_s1_xoff, r_s2_xoff;
   logic [YW-1:0] r_s1_yoff;
   logic [3:0]    r_s2_fg, r_s2_bg;
   logic [11:0]   r_rgb, w_rgb;
   logic [2:0]    r_hs_sr, r_vs_sr;
   logic          w_bit;

   assign o_font_addr = {r_ram_q[7:0], r_s1_yoff};
   assign w_bit       = i_font_data[XW'(CHAR_W - 1) - r_s2_xoff];
   assign w_rgb       = (w_bit || r_s2_cur) ? cga(r_s2_fg) : cga(r_s2_bg);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ram_q   <= '0;
         r_s1_disp <= 1'b0;
         r_s1_cur  <= 1'b0;
         r_s1_xoff <= '0;
         r_s1_yoff <= '0;
         r_s2_disp <= 1'b0;
         r_s2_cur  <= 1'b0;
         r_s2_xoff <= '0;
         r_s2_fg   <= '0;
         r_s2_bg   <= '0;
         r_rgb     <= '0;
         r_hs_sr   <= {3{~HS_POL}};
         r_vs_sr   <= {3{~VS_POL}};
      end else begin
         r_ram_q   <= r_ram[w_rd_addr];
         r_s1_disp <= w_disp;
         r_s1_cur  <= w_disp && i_cursor_en && r_blink_on && (w_addr == i_cursor_addr) &&
                      (w_yoff >= YW'(CHAR_H - 2));
         r_s1_xoff <= w_xoff;
         r_s1_yoff <= w_yoff;
         r_s2_disp <= r_s1_disp;
         r_s2_cur  <= r_s1_cur;
         r_s2_xoff <= r_s1_xoff;
         r_s2_fg   <= r_ram_q[11:8];
         r_s2_bg   <= r_ram_q[15:12];
         r_rgb     <= r_s2_disp ? w_rgb : 12'h000;
         r_hs_sr   <= {r_hs_sr[1:0], w_hs};
         r_vs_sr   <= {r_vs_sr[1:0], w_vs};
      end
   end

   assign o_vga_r  = r_rgb[11:8];
   assign o_vga_g  = r_rgb[7:4];
   assign o_vga_b  = r_rgb[3:0];
   assign o_vga_hs = r_hs_sr[2];
   assign o_vga_vs = r_vs_sr[2];
endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a reduced raster (44x54 clocks, 4x3 cells)
// with a registered font model and cycle-indexed pixel expectations.
module tb_vga_text_engine;
   localparam int HS = 4, HB = 4, HD = 32, HF = 4;
   localparam int VS = 2, VB = 2, VD = 48, VF = 2;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int FT = HT * VT;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_char = '0, wr_attr = '0;
   logic        clear = 1'b0, clear_busy;
   logic        cursor_en = 1'b0;
   logic [3:0]  cursor_addr = '0;
   logic [11:0] font_addr;
   logic [7:0]  font_data = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, frame_start;
   logic [11:0] rgb;
   int          cyc;
   int          n_cmp = 0, n_bad = 0;

   vga_text_engine #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .CHAR_W(8), .CHAR_H(16), .HS_POL(1'b1), .VS_POL(1'b1), .BLINK_FRAMES(2)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr),
      .i_wr_char(wr_char), .i_wr_attr(wr_attr),
      .i_clear(clear), .o_clear_busy(clear_busy),
      .i_cursor_en(cursor_en), .i_cursor_addr(cursor_addr),
      .o_font_addr(font_addr), .i_font_data(font_data),
      .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
      .o_vga_hs(vga_hs), .o_vga_vs(vga_vs), .o_frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; equals the DUT raster position H + V*HT.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   // Font ROM model: glyph 0x41 is a single left column, others echo the code.
   function automatic logic [7:0] font_fn(input logic [7:0] ch);
      return (ch == 8'h41) ? 8'h80 : ch;
   endfunction

   always @(posedge clk) font_data <= font_fn(font_addr[11:4]);

   assign rgb = {vga_r, vga_g, vga_b};

   // Cycle on which screen pixel (x,y) of frame f is on the pins.
   function automatic int pix_cyc(input int f, input int x, input int y);
      return f * FT + (VS + VB + y) * HT + HS + HB + x + 3;
   endfunction

   task automatic goto(input int n);
      int g = 0;
      while (cyc < n && g < 100000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != n) begin
         n_cmp++; n_bad++;
         $display("FAIL goto: at cycle %0d, wanted %0d", cyc, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL rst_rgb: got %h want 000", rgb); end
      n_cmp++; if (vga_hs !== 1'b0) begin n_bad++; $display("FAIL rst_hs: got %b want 0", vga_hs); end
      n_cmp++; if (vga_vs !== 1'b0) begin n_bad++; $display("FAIL rst_vs: got %b want 0", vga_vs); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
      n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", clear_busy); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL first_fs: got %b want 1", frame_start); end
      @(negedge clk);
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_one_cycle: got %b want 0", frame_start); end
   endtask

   task automatic test_timing();
      int tc[8] = '{2, 3, 6, 7, 46, 47, 90, 91};
      bit th[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
      bit tv[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
      int nfs = 0, nhs = 0, nvs = 0;
      for (int i = 0; i < 8; i++) begin
         goto(tc[i]);
         n_cmp++; if (vga_hs !== th[i]) begin n_bad++; $display("FAIL hs_c%0d: got %b want %b", tc[i], vga_hs, th[i]); end
         n_cmp++; if (vga_vs !== tv[i]) begin n_bad++; $display("FAIL vs_c%0d: got %b want %b", tc[i], vga_vs, tv[i]); end
      end
      goto(FT - 1);
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_before: got %b want 0", frame_start); end
      goto(FT);
      n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL fs_frame1: got %b want 1", frame_start); end
      for (int i = 0; i < FT; i++) begin
         @(negedge clk);
         nfs += int'(frame_start);
         nhs += int'(vga_hs);
         nvs += int'(vga_vs);
      end
      n_cmp++; if (nfs != 1) begin n_bad++; $display("FAIL fs_count: got %0d want 1", nfs); end
      n_cmp++; if (nhs != HS * VT) begin n_bad++; $display("FAIL hs_high: got %0d want %0d", nhs, HS * VT); end
      n_cmp++; if (nvs != VS * HT) begin n_bad++; $display("FAIL vs_high: got %0d want %0d", nvs, VS * HT); end
   endtask

   task automatic test_clear();
      int cnt = 0, rdy = 0;
      logic [11:0] e;
      clear = 1'b1; wr_valid = 1'b1; wr_addr = 4'd3; wr_attr = 8'h1F; wr_char = 8'h41;
      #1;
      n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_wr_ready: got %b want 0", wr_ready); end
      n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy_early: got %b want 0", clear_busy); end
      @(negedge clk);
      clear = 1'b0; wr_valid = 1'b0;
      while (clear_busy && cnt < 100) begin
         if (wr_ready) rdy++;
         cnt++;
         clear = (cnt == 5);
         @(negedge clk);
      end
      clear = 1'b0;
      n_cmp++; if (cnt != 13) begin n_bad++; $display("FAIL clr_busy_len: got %0d want 13", cnt); end
      n_cmp++; if (rdy != 0) begin n_bad++; $display("FAIL clr_ready_low: got %0d ready cycles want 0", rdy); end
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            for (int k = 0; k < 2; k++) begin
               e = (k == 1) ? 12'hAAA : 12'h000;
               goto(pix_cyc(2, c * 8 + 2 * k, r * 16 + 5));
               n_cmp++;
               if (rgb !== e) begin n_bad++; $display("FAIL clr_cell%0d_x%0d: got %h want %h", r * 4 + c, 2 * k, rgb, e); end
            end
   endtask

   task automatic test_write();
      logic [3:0]  wa[4] = '{4'd0, 4'd7, 4'd12, 4'd15};
      logic [15:0] wd[4] = '{16'h1F41, 16'h4E81, 16'hFF41, 16'h2D41};
      int          px[12] = '{-1, 0, 1, 7, 32, 0, 26, 24, 27, 31, 2, 0};
      int          py[12] = '{0, 0, 0, 0, 0, 15, 15, 16, 16, 16, 17, 48};
      logic [11:0] pe[12] = '{12'h000, 12'hFFF, 12'h00A, 12'h00A, 12'h000, 12'hFFF,
                              12'hAAA, 12'hFF5, 12'hA00, 12'hFF5, 12'hAAA, 12'h000};
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_addr = wa[i]; {wr_attr, wr_char} = wd[i];
         #1;
         n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready%0d: got %b want 1", i, wr_ready); end
         @(negedge clk);
      end
      wr_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         goto(pix_cyc(3, px[i], py[i]));
         n_cmp++;
         if (rgb !== pe[i]) begin n_bad++; $display("FAIL wr_px(%0d,%0d): got %h want %h", px[i], py[i], rgb, pe[i]); end
      end
   endtask

   task automatic test_cursor();
      int          px[4] = '{8, 0, 8, 12};
      int          py[4] = '{29, 30, 30, 31};
      logic [11:0] e;
      bit          on;
      cursor_en = 1'b1; cursor_addr = 4'd5;
      for (int f = 4; f < 8; f++) begin
         on = ((f / 2) % 2) == 0;
         for (int i = 0; i < 4; i++) begin
            e = (i >= 2 && on) ? 12'hAAA : 12'h000;
            goto(pix_cyc(f, px[i], py[i]));
            n_cmp++;
            if (rgb !== e) begin n_bad++; $display("FAIL cur_f%0d(%0d,%0d): got %h want %h", f, px[i], py[i], rgb, e); end
         end
      end
      cursor_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int t = pix_cyc(8, 2, 0);
      goto(t - 8);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      goto(t);
      n_cmp++; if (clear_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", clear_busy); end
      n_cmp++; if (rgb !== 12'hAAA) begin n_bad++; $display("FAIL mid_px: got %h want AAA", rgb); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL async_rgb: got %h want 000", rgb); end
      n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b want 0", clear_busy); end
      n_cmp++; if (vga_hs !== 1'b0 || vga_vs !== 1'b0) begin n_bad++; $display("FAIL async_sync: got %b%b want 00", vga_hs, vga_vs); end
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL async_ready: got %b want 1", wr_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL rerun_fs: got %b want 1", frame_start); end
      @(negedge clk);
      n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL clr_aborted: got %b want 0", clear_busy); end
      goto(3);
      n_cmp++; if (vga_hs !== 1'b1) begin n_bad++; $display("FAIL rerun_hs: got %b want 1", vga_hs); end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_clear();
      test_write();
      test_cursor();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
